// File: rtl/mult_pipe.sv
// mult_pipe: fully pipelined shift-add multiplier, one multiplier bit per stage.
// Optional two's-complement mode is compiled in with MULT_PIPE_SIGNED_EN.
module mult_pipe #(
    parameter int N = 4,
    parameter int M = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     mcand,
    input  logic [M-1:0]     mplier,
`ifdef MULT_PIPE_SIGNED_EN
    input  logic             sgn,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N+M-1:0]   product,
    output logic             busy
);

    localparam int W = N + M;

    // Stage registers: stage k has retired multiplier bits 0..k.
    logic [M-1:0] vld;
    logic [W-1:0] acc [M];
    logic [W-1:0] mc  [M];
    logic [M-1:0] mp  [M];

    // Next-state values for every stage, computed from the stage before.
    logic [M-1:0] d_vld;
    logic [W-1:0] d_acc [M];
    logic [W-1:0] d_mc  [M];
    logic [M-1:0] d_mp  [M];

`ifdef MULT_PIPE_SIGNED_EN
    logic [M-1:0] sg;
    logic [M-1:0] d_sg;
`endif

    logic         stall;
    logic [W-1:0] ext;

    assign stall     = vld[M-1] && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = vld[M-1];
    assign product   = acc[M-1];
    assign busy      = |vld;

    // Widen the multiplicand; sign-extend only for signed entries.
`ifdef MULT_PIPE_SIGNED_EN
    assign ext = {{M{sgn & mcand[N-1]}}, mcand};
`else
    assign ext = {{M{1'b0}}, mcand};
`endif

    // Partial-product chain: stage k adds (or, for a signed entry in the
    // last stage, subtracts) the multiplicand shifted by k when bit k is set.
    always_comb begin
        logic [W-1:0] addend;
        addend   = '0;
        d_vld    = '0;
        d_vld[0] = in_valid;
        d_mc[0]  = ext;
        d_mp[0]  = mplier;
        d_acc[0] = mplier[0] ? ext : '0;
`ifdef MULT_PIPE_SIGNED_EN
        d_sg     = '0;
        d_sg[0]  = sgn;
`endif
        for (int k = 1; k < M; k++) begin
            d_vld[k] = vld[k-1];
            d_mc[k]  = mc[k-1] << 1;
            d_mp[k]  = mp[k-1] >> 1;
            addend   = d_mp[k][0] ? d_mc[k] : '0;
`ifdef MULT_PIPE_SIGNED_EN
            d_sg[k]  = sg[k-1];
            if (k == M - 1 && sg[k-1]) begin
                d_acc[k] = acc[k-1] - addend;
            end else begin
                d_acc[k] = acc[k-1] + addend;
            end
`else
            d_acc[k] = acc[k-1] + addend;
`endif
        end
    end

    // Advance every stage together; a downstream stall freezes the lot.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
`ifdef MULT_PIPE_SIGNED_EN
            sg  <= '0;
`endif
            for (int k = 0; k < M; k++) begin
                acc[k] <= '0;
                mc[k]  <= '0;
                mp[k]  <= '0;
            end
        end else if (!stall) begin
            vld <= d_vld;
`ifdef MULT_PIPE_SIGNED_EN
            sg  <= d_sg;
`endif
            for (int k = 0; k < M; k++) begin
                acc[k] <= d_acc[k];
                mc[k]  <= d_mc[k];
                mp[k]  <= d_mp[k];
            end
        end
    end

endmodule
